// File: rtl/uart_rx_engine_if.sv
// Receive-side handshake bundle for uart_rx_engine: word, flags and valid/ready.
interface uart_rx_engine_if #(
  parameter int unsigned N = 8
) ();
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         data_ready;
  logic         parity_error;
  logic         framing_error;
  logic         overrun_error;
  logic         busy;

  modport master (
    output data_out, data_valid, parity_error, framing_error, overrun_error, busy,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_error, framing_error, overrun_error, busy,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver with synchroniser, 3-sample majority vote,
// false-start rejection, parity/framing flags and a valid/ready output with overrun.
module uart_rx_engine #(
  parameter int unsigned NUMBER_OF_DATA_BITS = 8,
  parameter int unsigned OVERSAMPLE          = 16,
  parameter int unsigned PARITY_MODE         = 0,
  parameter int unsigned NUMBER_OF_STOP_BITS = 1,
  parameter logic [31:0] BAUDRATE            = 32'd9600,
  parameter logic [31:0] FREQUENCY           = 32'd100000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  uart_rx_engine_if.master  bus
);

  localparam int unsigned N       = NUMBER_OF_DATA_BITS;
  localparam int unsigned DIV_RAW = FREQUENCY / (BAUDRATE * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW      = $clog2(OVERSAMPLE) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic           sync1_q, sync2_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     bitn_q, bitn_d;
  logic           stopn_q, stopn_d;
  logic [1:0]     samp_q, samp_d;
  logic [N-1:0]   shift_q, shift_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           armed_q, armed_d;
  logic           deliver_q, deliver_d;
  logic [N-1:0]   data_out_q, data_out_d;
  logic           valid_q, valid_d;
  logic           pe_q, pe_d;
  logic           fe_q, fe_d;
  logic           ovr_q, ovr_d;

  logic tick, rxs, maj, at_last;

  assign rxs     = sync2_q;
  assign tick    = (div_q == DW'(DIV - 1));
  assign div_d   = tick ? '0 : div_q + 1'b1;
  assign at_last = (cnt_q == CW'(OVERSAMPLE - 1));
  // Majority over the two earlier samples of this bit and the current one.
  assign maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    stopn_d   = stopn_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    armed_d   = armed_q;
    deliver_d = 1'b0;

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (rxs) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            cnt_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == CW'(OVERSAMPLE / 2 - 1)) begin
            cnt_d  = '0;
            bitn_d = '0;
            state_d = rxs ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          samp_d = {samp_q[0], rxs};
          if (at_last) begin
            cnt_d = '0;
            unique case (state_q)
              S_DATA: begin
                shift_d = {maj, shift_q[N-1:1]};
                stopn_d = 1'b0;
                if (bitn_q == 4'(N - 1)) begin
                  state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                end else begin
                  bitn_d = bitn_q + 1'b1;
                end
              end
              S_PARITY: begin
                perr_d  = ((^shift_q) ^ maj) != (PARITY_MODE == 1);
                state_d = S_STOP;
              end
              default: begin
                ferr_d = ferr_q | ~maj;
                if (stopn_q == 1'(NUMBER_OF_STOP_BITS - 1)) begin
                  state_d   = S_IDLE;
                  deliver_d = 1'b1;
                  // A low stop bit (e.g. line break) must see the line high before re-arming.
                  armed_d   = ~(ferr_q | ~maj);
                end else begin
                  stopn_d = 1'b1;
                end
              end
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    valid_d    = valid_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    ovr_d      = 1'b0;
    if (deliver_q) begin
      if (!valid_q || bus.data_ready) begin
        data_out_d = shift_q;
        pe_d       = perr_q;
        fe_d       = ferr_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      bitn_q     <= '0;
      stopn_q    <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b1;
      deliver_q  <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      stopn_q    <= stopn_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      armed_q    <= armed_d;
      deliver_q  <= deliver_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.data_valid    = valid_q;
  assign bus.parity_error  = pe_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun_error = ovr_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: 8N1 and 8E1 instances, one clk per sample tick.
module tb_uart_rx_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line = 1'b1;
  logic sel_par = 1'b0;
  logic rx0, rx2;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ovr_cnt = 0;

  always #5 clk = ~clk;

  assign rx0 = sel_par ? 1'b1 : line;
  assign rx2 = sel_par ? line : 1'b1;

  uart_rx_engine_if #(.N(8)) if0 ();
  uart_rx_engine_if #(.N(8)) if2 ();

  uart_rx_engine #(
    .NUMBER_OF_DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .NUMBER_OF_STOP_BITS(1),
    .BAUDRATE(32'd100), .FREQUENCY(32'd1600)
  ) dut0 (.clk(clk), .reset(reset), .rx(rx0), .bus(if0));

  uart_rx_engine #(
    .NUMBER_OF_DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .NUMBER_OF_STOP_BITS(1),
    .BAUDRATE(32'd100), .FREQUENCY(32'd1600)
  ) dut2 (.clk(clk), .reset(reset), .rx(rx2), .bus(if2));

  always @(negedge clk) if (if0.overrun_error === 1'b1) ovr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
  endtask

  task automatic send8p(input logic [7:0] d, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(1'b1);
  endtask

  task automatic accept0();
    if0.data_ready = 1'b1;
    @(negedge clk);
    if0.data_ready = 1'b0;
  endtask

  initial begin
    if0.data_ready = 1'b0;
    if2.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", if0.data_valid, 1'b0);
    chk("rst_data", if0.data_out, 8'h00);
    chk("rst_busy", if0.busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_valid", if0.data_valid, 1'b0);
    chk("idle_pe", if0.parity_error, 1'b0);
    chk("idle_fe", if0.framing_error, 1'b0);
    chk("idle_ovr", if0.overrun_error, 1'b0);
    chk("idle_busy", if0.busy, 1'b0);
    chk("idle_valid2", if2.data_valid, 1'b0);

    // 8N1 0xA5, held until accepted
    send8(8'hA5);
    repeat (3) @(negedge clk);
    chk("a5_valid", if0.data_valid, 1'b1);
    chk("a5_data", if0.data_out, 8'hA5);
    chk("a5_pe", if0.parity_error, 1'b0);
    chk("a5_fe", if0.framing_error, 1'b0);
    repeat (20) @(negedge clk);
    chk("a5_held", if0.data_valid, 1'b1);
    accept0();
    chk("a5_accept", if0.data_valid, 1'b0);
    chk("a5_data_hold", if0.data_out, 8'hA5);

    // false start
    line = 1'b0;
    repeat (4) @(negedge clk);
    chk("fs_busy", if0.busy, 1'b1);
    line = 1'b1;
    repeat (20) @(negedge clk);
    chk("fs_idle", if0.busy, 1'b0);
    chk("fs_novalid", if0.data_valid, 1'b0);

    // 0xFF with a 1-clk low glitch in the middle of data bit 2
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    line = 1'b1;
    repeat (7) @(negedge clk);
    line = 1'b0;
    @(negedge clk);
    line = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 3; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (3) @(negedge clk);
    chk("glitch_valid", if0.data_valid, 1'b1);
    chk("glitch_data", if0.data_out, 8'hFF);
    accept0();

    // even parity instance
    sel_par = 1'b1;
    send8p(8'h03, 1'b1);
    repeat (3) @(negedge clk);
    chk("par1_valid", if2.data_valid, 1'b1);
    chk("par1_data", if2.data_out, 8'h03);
    chk("par1_pe", if2.parity_error, 1'b1);
    chk("par1_fe", if2.framing_error, 1'b0);
    if2.data_ready = 1'b1;
    @(negedge clk);
    if2.data_ready = 1'b0;
    chk("par1_accept", if2.data_valid, 1'b0);
    send8p(8'h03, 1'b0);
    repeat (3) @(negedge clk);
    chk("par0_valid", if2.data_valid, 1'b1);
    chk("par0_data", if2.data_out, 8'h03);
    chk("par0_pe", if2.parity_error, 1'b0);
    chk("par_dut0_quiet", if0.data_valid, 1'b0);
    sel_par = 1'b0;
    repeat (4) @(negedge clk);

    // line break
    line = 1'b0;
    repeat (300) @(negedge clk);
    chk("brk_valid", if0.data_valid, 1'b1);
    chk("brk_data", if0.data_out, 8'h00);
    chk("brk_fe", if0.framing_error, 1'b1);
    chk("brk_busy", if0.busy, 1'b0);
    accept0();
    repeat (50) @(negedge clk);
    chk("brk_noretrig_busy", if0.busy, 1'b0);
    chk("brk_noretrig_valid", if0.data_valid, 1'b0);
    line = 1'b1;
    repeat (20) @(negedge clk);
    send8(8'h3C);
    repeat (3) @(negedge clk);
    chk("3c_valid", if0.data_valid, 1'b1);
    chk("3c_data", if0.data_out, 8'h3C);
    chk("3c_fe", if0.framing_error, 1'b0);
    chk("3c_pe", if0.parity_error, 1'b0);

    // reset during data bit 3 of 0x5A (0x3C still pending)
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    line = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_busy", if0.busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_valid", if0.data_valid, 1'b0);
    chk("mrst_data", if0.data_out, 8'h00);
    chk("mrst_busy", if0.busy, 1'b0);
    reset = 1'b0;
    line = 1'b1;
    repeat (32) @(negedge clk);
    chk("mrst_novalid", if0.data_valid, 1'b0);
    send8(8'h5A);
    repeat (3) @(negedge clk);
    chk("5a_valid", if0.data_valid, 1'b1);
    chk("5a_data", if0.data_out, 8'h5A);
    accept0();

    // overrun
    chk("no_early_ovr", ovr_cnt, 0);
    send8(8'h11);
    send8(8'h22);
    repeat (4) @(negedge clk);
    chk("ovr_data", if0.data_out, 8'h11);
    chk("ovr_valid", if0.data_valid, 1'b1);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_low", if0.overrun_error, 1'b0);
    accept0();
    chk("ovr_accept", if0.data_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
